// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Holds the FSM state encoding, the requester port ids and the word-alignment helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam logic [1:0] WORD_MASK = 2'b11;

  function automatic logic misaligned(input logic [1:0] lsb);
    return (lsb & WORD_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle for the fetch and load/store ports plus the memory side.
// slave is the arbiter's view; master is the view of the core and memory around it.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic [31:0]       i_rdata;
  logic              i_err;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_done;
  logic [31:0]       d_rdata;
  logic              d_err;

  logic              busy;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_adr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_done, i_rdata, i_err, d_done, d_rdata, d_err,
           busy, mem_write, mem_adr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_done, i_rdata, i_err, d_done, d_rdata, d_err,
           busy, mem_write, mem_adr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and load/store requests.
// Fixed mode always favours D; round-robin mode gives a tie to the port not served last.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int RR_MODE = 0
) (
  input  logic i_req,
  input  logic d_req,
  input  logic last_served,
  output logic pick,
  output logic vld
);

  always_comb begin
    vld  = i_req | d_req;
    pick = PORT_D;
    if (i_req && d_req) begin
      pick = (RR_MODE != 0) ? ~last_served : PORT_D;
    end else if (i_req) begin
      pick = PORT_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch (I) and load/store (D); done pulses 2 cycles after the request.
// Requesters hold req until their done; one access per 3 cycles, bad addresses finish without touching memory.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 65536,
  parameter int RR_MODE   = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 4);

  state_t            state;
  logic              lat_port;
  logic              lat_err;
  logic              last_served;

  logic              pick_port;
  logic              pick_vld;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic              sel_err;

  logic              i_done_q;
  logic              i_err_q;
  logic [31:0]       i_rdata_q;
  logic              d_done_q;
  logic              d_err_q;
  logic [31:0]       d_rdata_q;
  logic              busy_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_adr_q;
  logic [31:0]       mem_wdata_q;

  mem_arb_pick #(
    .RR_MODE (RR_MODE)
  ) u_pick (
    .i_req       (bus.i_req),
    .d_req       (bus.d_req),
    .last_served (last_served),
    .pick        (pick_port),
    .vld         (pick_vld)
  );

  always_comb begin
    sel_addr = (pick_port == PORT_D) ? bus.d_addr : bus.i_addr;
    sel_we   = (pick_port == PORT_D) && bus.d_we;
    sel_err  = misaligned(sel_addr[1:0]) || (sel_addr > MAX_ADDR);
  end

  // mem_write is a register so an asynchronous reset removes it mid-access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lat_port    <= PORT_I;
      lat_err     <= 1'b0;
      last_served <= PORT_I;
      i_done_q    <= 1'b0;
      i_err_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_done_q    <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
      mem_write_q <= 1'b0;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            lat_port    <= pick_port;
            lat_err     <= sel_err;
            last_served <= pick_port;
            mem_adr_q   <= sel_addr;
            mem_wdata_q <= bus.d_wdata;
            mem_write_q <= sel_we && !sel_err;
            busy_q      <= 1'b1;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          mem_write_q <= 1'b0;
          if (lat_port == PORT_D) begin
            d_done_q  <= 1'b1;
            d_err_q   <= lat_err;
            d_rdata_q <= lat_err ? 32'h0 : bus.mem_rdata;
          end else begin
            i_done_q  <= 1'b1;
            i_err_q   <= lat_err;
            i_rdata_q <= lat_err ? 32'h0 : bus.mem_rdata;
          end
          state <= DONE;
        end
        DONE: begin
          i_done_q <= 1'b0;
          i_err_q  <= 1'b0;
          d_done_q <= 1'b0;
          d_err_q  <= 1'b0;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          mem_write_q <= 1'b0;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.i_done    = i_done_q;
  assign bus.i_err     = i_err_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_done    = d_done_q;
  assign bus.d_err     = d_err_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = busy_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_adr   = mem_adr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a fixed-priority and a round-robin instance share one memory model,
// exercised by a directed vector table, corner-case sequences and a transaction-level random model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int MEM_WORDS = 16384;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic preload = 1'b1;
  always #5 clk = ~clk;

  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;

  logic [31:0] mem [MEM_WORDS];
  logic [31:0] shadow [MEM_WORDS];

  mem_arbiter_if #(.ADDR_W(32)) bus0 ();
  mem_arbiter_if #(.ADDR_W(32)) bus1 ();

  assign bus0.i_req     = i_req & ~sel;
  assign bus0.d_req     = d_req & ~sel;
  assign bus0.i_addr    = i_addr;
  assign bus0.d_addr    = d_addr;
  assign bus0.d_we      = d_we;
  assign bus0.d_wdata   = d_wdata;
  assign bus0.mem_rdata = mem[bus0.mem_adr[15:2]];
  assign bus1.i_req     = i_req & sel;
  assign bus1.d_req     = d_req & sel;
  assign bus1.i_addr    = i_addr;
  assign bus1.d_addr    = d_addr;
  assign bus1.d_we      = d_we;
  assign bus1.d_wdata   = d_wdata;
  assign bus1.mem_rdata = mem[bus1.mem_adr[15:2]];

  mem_arbiter #(.ADDR_W(32), .MEM_BYTES(65536), .RR_MODE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mem_arbiter #(.ADDR_W(32), .MEM_BYTES(65536), .RR_MODE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic        i_done, i_err, d_done, d_err, busy, mem_write;
  logic [31:0] i_rdata, d_rdata, mem_adr, mem_wdata;

  always_comb begin
    i_done = sel ? bus1.i_done : bus0.i_done;
    i_err = sel ? bus1.i_err : bus0.i_err;
    i_rdata = sel ? bus1.i_rdata : bus0.i_rdata;
    d_done = sel ? bus1.d_done : bus0.d_done;
    d_err = sel ? bus1.d_err : bus0.d_err;
    d_rdata = sel ? bus1.d_rdata : bus0.d_rdata;
    busy = sel ? bus1.busy : bus0.busy;
    mem_write = sel ? bus1.mem_write : bus0.mem_write;
    mem_adr = sel ? bus1.mem_adr : bus0.mem_adr;
    mem_wdata = sel ? bus1.mem_wdata : bus0.mem_wdata;
  end

  function automatic logic [31:0] preload_val(input int k);
    if (k == 32'h40) return 32'hDEAD_BEEF;
    if (k == 32'h3FFF) return 32'hCAFE_F00D;
    if (k == 16) return 32'h0BAD_F00D;
    return (32'(k) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < MEM_WORDS; k++) mem[k] <= preload_val(k);
    end else if (mem_write) begin
      mem[mem_adr[15:2]] <= mem_wdata;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vec [12];

  // Single access on one port from an IDLE cycle; returns at the IDLE cycle after DONE.
  task automatic do_access(input logic port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic err, output int lat, output int wr_cnt,
                           output int other_done);
    lat = -1; wr_cnt = 0; other_done = 0; rdata = 32'h0; err = 1'b0;
    if (port) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      wr_cnt += int'(mem_write);
      other_done += int'(port ? i_done : d_done);
      if (port ? d_done : i_done) begin
        lat = k;
        rdata = port ? d_rdata : i_rdata;
        err = port ? d_err : i_err;
        break;
      end
    end
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    wr_cnt += int'(mem_write);
  endtask

  task automatic contend(input logic [31:0] ia, input logic [31:0] da,
                         output int il, output int dl,
                         output logic [31:0] ir, output logic [31:0] dr);
    il = -1; dl = -1; ir = 32'h0; dr = 32'h0;
    i_req = 1'b1; i_addr = ia; d_req = 1'b1; d_we = 1'b0; d_addr = da;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (d_done && dl < 0) begin dl = k; dr = d_rdata; d_req = 1'b0; end
      if (i_done && il < 0) begin il = k; ir = i_rdata; i_req = 1'b0; end
      if (il >= 0 && dl >= 0) break;
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int r;
    r = $urandom_range(0, 15);
    a = 32'($urandom_range(0, 63)) << 2;
    if (r == 0) a = 32'h0000_FFFC;
    else if (r == 1) a = 32'h0001_0000 + (32'($urandom_range(0, 3)) << 2);
    else if (r == 2) a = a | 32'($urandom_range(1, 3));
    return a;
  endfunction

  logic [31:0] rd, ir, dr;
  logic        er;
  int          lat, wr, oth, il, dl;
  int          bb_done [3];
  logic        bb_busy [12];

  initial begin
    vec[0]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0};
    vec[1]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, preload_val(8), 1'b0};
    vec[2]  = '{1'b0, 1'b0, 32'h0000_0020, 32'h0, 32'h1234_5678, 1'b0};
    vec[3]  = '{1'b1, 1'b1, 32'h0000_0102, 32'h7777_7777, 32'h0, 1'b1};
    vec[4]  = '{1'b0, 1'b0, 32'h0000_FFFE, 32'h0, 32'h0, 1'b1};
    vec[5]  = '{1'b0, 1'b0, 32'h0000_FFFC, 32'h0, 32'hCAFE_F00D, 1'b0};
    vec[6]  = '{1'b1, 1'b0, 32'h0001_0000, 32'h0, 32'h0, 1'b1};
    vec[7]  = '{1'b1, 1'b0, 32'h0000_0021, 32'h0, 32'h0, 1'b1};
    vec[8]  = '{1'b0, 1'b0, 32'h0000_0001, 32'h0, 32'h0, 1'b1};
    vec[9]  = '{1'b1, 1'b1, 32'h0000_FFFC, 32'hA5A5_5A5A, 32'hCAFE_F00D, 1'b0};
    vec[10] = '{1'b1, 1'b0, 32'h0000_FFFC, 32'h0, 32'hA5A5_5A5A, 1'b0};
    vec[11] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0};

    i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    repeat (2) @(negedge clk);
    preload = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      #1;
      check($sformatf("reset%0d_flags", s), 32'({i_done, d_done, i_err, d_err, busy, mem_write}), 32'h0);
      check($sformatf("reset%0d_rdata", s), i_rdata | d_rdata, 32'h0);
      check($sformatf("reset%0d_mem_bus", s), mem_adr | mem_wdata, 32'h0);
    end
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 12; k++) begin
      do_access(vec[k].port, vec[k].we, vec[k].addr, vec[k].wdata, rd, er, lat, wr, oth);
      check($sformatf("vec%0d_latency", k), 32'(lat), 32'd2);
      check($sformatf("vec%0d_rdata", k), rd, vec[k].exp_rdata);
      check($sformatf("vec%0d_err", k), 32'(er), 32'(vec[k].exp_err));
      check($sformatf("vec%0d_write_cycles", k), 32'(wr), 32'(vec[k].we && !vec[k].exp_err));
      check($sformatf("vec%0d_other_done", k), 32'(oth), 32'd0);
    end

    contend(32'h0, 32'h4, il, dl, ir, dr);
    check("fixed_contend_d_lat", 32'(dl), 32'd2);
    check("fixed_contend_i_lat", 32'(il), 32'd5);
    check("fixed_contend_d_rdata", dr, preload_val(1));
    check("fixed_contend_i_rdata", ir, preload_val(0));

    sel = 1'b1;
    do_access(1'b1, 1'b0, 32'h8, 32'h0, rd, er, lat, wr, oth);
    check("rr_d_first_rdata", rd, preload_val(2));
    contend(32'h0, 32'h4, il, dl, ir, dr);
    check("rr_after_d_i_lat", 32'(il), 32'd2);
    check("rr_after_d_d_lat", 32'(dl), 32'd5);
    do_access(1'b0, 1'b0, 32'hC, 32'h0, rd, er, lat, wr, oth);
    check("rr_i_alone_rdata", rd, preload_val(3));
    contend(32'h10, 32'h14, il, dl, ir, dr);
    check("rr_after_i_d_lat", 32'(dl), 32'd2);
    check("rr_after_i_i_lat", 32'(il), 32'd5);
    check("rr_after_i_i_rdata", ir, preload_val(4));

    sel = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hFFFF_0000;
    @(negedge clk);
    check("rstmid_write_in_access", 32'(mem_write), 32'd1);
    rst_n = 1'b0; d_req = 1'b0; d_we = 1'b0;
    #1;
    check("rstmid_flags", 32'({i_done, d_done, i_err, d_err, busy, mem_write}), 32'h0);
    check("rstmid_rdata", i_rdata | d_rdata, 32'h0);
    check("rstmid_mem_bus", mem_adr | mem_wdata, 32'h0);
    @(negedge clk);
    check("rstmid_mem_word", mem[16], 32'h0BAD_F00D);
    rst_n = 1'b1;
    @(negedge clk);
    do_access(1'b1, 1'b0, 32'h40, 32'h0, rd, er, lat, wr, oth);
    check("rstmid_after_latency", 32'(lat), 32'd2);
    check("rstmid_after_rdata", rd, 32'h0BAD_F00D);

    bb_done = '{-1, -1, -1};
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0;
    for (int k = 1; k < 12; k++) begin
      int n;
      @(negedge clk);
      bb_busy[k] = busy;
      n = 0;
      while (n < 3 && bb_done[n] >= 0) n++;
      if (d_done && n < 3) begin
        bb_done[n] = k;
        check($sformatf("b2b_rdata%0d", n), d_rdata, preload_val(n));
        d_addr = 32'(n + 1) << 2;
        if (n == 2) d_req = 1'b0;
      end
    end
    check("b2b_done0", 32'(bb_done[0]), 32'd2);
    check("b2b_done1", 32'(bb_done[1]), 32'd5);
    check("b2b_done2", 32'(bb_done[2]), 32'd8);
    check("b2b_busy_final_done", 32'(bb_busy[8]), 32'd1);
    check("b2b_busy_after", 32'(bb_busy[9]), 32'd0);

    for (int m = 0; m < 2; m++) begin
      int free, edi, edd, ewr, gcyc;
      logic last, pi, pd, gi, gd, w, we, err;
      logic [31:0] ti_addr, td_addr, td_wdata, eri, erd, a;
      logic td_we, eei, eed;
      i_req = 1'b0; d_req = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      sel = (m == 1);
      rst_n = 1'b1;
      for (int k = 0; k < MEM_WORDS; k++) shadow[k] = mem[k];
      free = 0; edi = -1; edd = -1; ewr = -1; gcyc = -10;
      last = 1'b0; pi = 1'b0; pd = 1'b0; gi = 1'b0; gd = 1'b0;
      ti_addr = 0; td_addr = 0; td_wdata = 0; td_we = 1'b0;
      eri = 0; erd = 0; eei = 1'b0; eed = 1'b0;
      for (int c = 0; c < 400; c++) begin
        check($sformatf("rnd%0d_c%0d_i_done", m, c), 32'(i_done), 32'(c == edi));
        check($sformatf("rnd%0d_c%0d_d_done", m, c), 32'(d_done), 32'(c == edd));
        check($sformatf("rnd%0d_c%0d_mem_write", m, c), 32'(mem_write), 32'(c == ewr));
        check($sformatf("rnd%0d_c%0d_busy", m, c), 32'(busy), 32'(c == gcyc + 1 || c == gcyc + 2));
        if (c == edi) begin
          check($sformatf("rnd%0d_c%0d_i_rdata", m, c), i_rdata, eri);
          check($sformatf("rnd%0d_c%0d_i_err", m, c), 32'(i_err), 32'(eei));
          pi = 1'b0; gi = 1'b0;
        end
        if (c == edd) begin
          check($sformatf("rnd%0d_c%0d_d_rdata", m, c), d_rdata, erd);
          check($sformatf("rnd%0d_c%0d_d_err", m, c), 32'(d_err), 32'(eed));
          pd = 1'b0; gd = 1'b0;
        end
        if (!pi && $urandom_range(0, 2) == 0) begin
          pi = 1'b1; ti_addr = rand_addr();
        end
        if (!pd && $urandom_range(0, 2) == 0) begin
          pd = 1'b1; td_addr = rand_addr(); td_we = 1'($urandom_range(0, 1)); td_wdata = $urandom;
        end
        i_req = pi; d_req = pd;
        i_addr = gi ? $urandom : ti_addr;
        d_addr = gd ? $urandom : td_addr;
        d_we = gd ? 1'($urandom_range(0, 1)) : td_we;
        d_wdata = gd ? $urandom : td_wdata;
        // Arbiter accepts a new access only three cycles after the previous grant.
        if (c >= free && (pi || pd)) begin
          if (pi && pd) w = (m == 0) ? 1'b1 : ~last;
          else w = pd;
          a = w ? td_addr : ti_addr;
          we = w && td_we;
          err = (a % 4 != 0) || (a > 32'd65532);
          if (w) begin
            edd = c + 2; eed = err; erd = err ? 32'h0 : shadow[a >> 2]; gd = 1'b1;
          end else begin
            edi = c + 2; eei = err; eri = err ? 32'h0 : shadow[a >> 2]; gi = 1'b1;
          end
          if (we && !err) begin
            shadow[a >> 2] = td_wdata;
            ewr = c + 1;
          end
          last = w; free = c + 3; gcyc = c;
        end
        @(negedge clk);
      end
      i_req = 1'b0; d_req = 1'b0;
      repeat (4) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
